sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
- Upstream front-end for the car-park FSM/counter DUT.
- Takes the raw, asynchronous, bouncy photo-sensor lines, synchronises and debounces each one, and drives clean `a`/`b` levels into the DUT.
- Also detects a sensor stuck in the blocked state. It raises a sticky per-channel fault and masks that channel to 0 so the FSM cannot lock up.

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronised input must differ from the current clean level before the clean level flips (≥2).
- STUCK_CYCLES, 64: consecutive cycles a clean level may stay 1 before the channel is declared stuck (> DB_CYCLES).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- raw_a  in  1  raw outer sensor, asynchronous to clk, 1 = beam blocked.
- raw_b  in  1  raw inner sensor, asynchronous to clk, 1 = beam blocked.
- clear_fault  in  1  synchronous pulse; clears both fault flags and both stuck counters.
- a  out  1  conditioned outer sensor level to DUT.
- b  out  1  conditioned inner sensor level to DUT.
- fault_a  out  1  sticky stuck-high flag, channel a.
- fault_b  out  1  sticky stuck-high flag, channel b.

Behaviour:
- Reset (async assert, sync release):
  - All flops go to 0: sync stages, clean levels, debounce counters, stuck counters, faults.
  - Hence `a`=`b`=`fault_a`=`fault_b`=0.
  - Reset asserted mid-debounce or mid-stuck-count discards all progress.
- Channels a and b are identical and fully independent. There is no cross-coupling, so simultaneous events on both channels are handled in parallel.
- Synchroniser:
  - Two-flop chain per channel: raw → s1 → s2.
  - s2 is the only value used downstream.
- Debounce per channel (state: clean level L, counter dcnt, width ceil(log2(DB_CYCLES))+1):
  - If s2 == L: dcnt ← 0.
  - If s2 != L and dcnt < DB_CYCLES-1: dcnt ← dcnt+1.
  - If s2 != L and dcnt == DB_CYCLES-1: L ← s2, dcnt ← 0.
- Debounce latency:
  - A raw level held stable reaches L exactly 2+DB_CYCLES rising edges after the first edge that samples it into s1.
  - Any s2 excursion shorter than DB_CYCLES cycles is filtered: dcnt returns to 0 and L is unchanged.
- Stuck detection per channel (scnt saturating, width ceil(log2(STUCK_CYCLES))+1):
  - L==0: scnt ← 0.
  - L==1 and fault==0: scnt ← scnt+1. When scnt reaches STUCK_CYCLES-1 with L still 1, fault ← 1 on that edge.
  - fault==1: scnt holds. fault stays 1 until rst or clear_fault.
- clear_fault has priority over a same-cycle stuck detection:
  - fault ← 0 and scnt ← 0 for both channels.
  - If L remains 1, counting restarts and the fault re-asserts STUCK_CYCLES cycles later.
- Outputs (all registered; no combinational path from any input to any output):
  - `a` = L_a & ~fault_a.
  - `b` = L_b & ~fault_b.
  - `fault_a`/`fault_b` driven directly from flops.
- Debounce continues while a fault is set. The stored L stays accurate, and the output unmasks immediately on clear_fault if L==0.

Test Plan:
- Use DB_CYCLES=4 and STUCK_CYCLES=16 for all scenarios.
- Clean step: raw_a 0→1 held 10 cycles → `a` rises exactly 6 edges after the first sampling edge. `b` and the faults stay 0. raw_a 1→0 → `a` falls 6 edges later.
- Bounce filter: raw_a pulses high for 3 cycles, low for 2, high for 3 → `a` stays 0 throughout. Then raw_a held high 5 cycles → `a` rises 6 edges after that final rise is sampled.
- Parallel car entry (a then b overlap): raw_a high at t0, raw_b high at t0+3, raw_a low at t0+8, raw_b low at t0+11 → `a`/`b` reproduce the same sequence shifted by 6 cycles. DUT `car_count` increments by 1.
- Stuck sensor: raw_b held high 40 cycles → `b`=1 for 15 cycles, then `fault_b`=1 and `b`=0. A clear_fault pulse with raw_b still high → `fault_b`=0, `b`=1 for 15 cycles, then `fault_b` re-asserts.
- Priority: clear_fault asserted on the same edge scnt_a reaches threshold → `fault_a` remains 0 and scnt_a is 0.
- Async reset mid-debounce: raw_a high, rst asserted 2 cycles in (between clock edges) → all outputs 0 immediately. After release, with raw_a still high, `a` rises 6 edges later.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Front-end for the car-park sensors: two-flop synchronisers, per-channel debounce,
// and a sticky stuck-high detector that masks a channel whose beam never clears.
module sensor_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int STUCK_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    input  logic clear_fault,
    output logic a,
    output logic b,
    output logic fault_a,
    output logic fault_b
);

    localparam int DW = $clog2(DB_CYCLES) + 1;
    localparam int SW = $clog2(STUCK_CYCLES) + 1;

    logic [1:0] raw_w;
    logic [1:0] out_w;
    logic [1:0] fault_w;

    assign raw_w = {raw_b, raw_a};

    // Index 0 is channel a, index 1 is channel b; the channels share nothing but clear_fault.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic          s1_q;
        logic          s2_q;
        logic          lvl_q;
        logic          lvl_d;
        logic          fault_q;
        logic          fault_d;
        logic [DW-1:0] dcnt_q;
        logic [DW-1:0] dcnt_d;
        logic [SW-1:0] scnt_q;
        logic [SW-1:0] scnt_d;

        always_comb begin
            lvl_d  = lvl_q;
            dcnt_d = '0;
            if (s2_q != lvl_q) begin
                if (dcnt_q == DW'(DB_CYCLES - 1)) begin
                    lvl_d = s2_q;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
        end

        // The fault fires on the edge the counter reaches STUCK_CYCLES-1; it then holds there.
        always_comb begin
            scnt_d  = scnt_q;
            fault_d = fault_q;
            if (clear_fault) begin
                scnt_d  = '0;
                fault_d = 1'b0;
            end else if (!lvl_q) begin
                scnt_d = '0;
            end else if (!fault_q) begin
                scnt_d = scnt_q + SW'(1);
                if (scnt_q == SW'(STUCK_CYCLES - 2)) begin
                    fault_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                lvl_q   <= 1'b0;
                dcnt_q  <= '0;
                scnt_q  <= '0;
                fault_q <= 1'b0;
            end else begin
                s1_q    <= raw_w[gi];
                s2_q    <= s1_q;
                lvl_q   <= lvl_d;
                dcnt_q  <= dcnt_d;
                scnt_q  <= scnt_d;
                fault_q <= fault_d;
            end
        end

        assign out_w[gi]   = lvl_q & ~fault_q;
        assign fault_w[gi] = fault_q;
    end

    assign a       = out_w[0];
    assign b       = out_w[1];
    assign fault_a = fault_w[0];
    assign fault_b = fault_w[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DB_CYCLES=4, STUCK_CYCLES=16.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_sensor_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic raw_a;
    logic raw_b;
    logic clear_fault;
    logic a;
    logic b;
    logic fault_a;
    logic fault_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sensor_conditioner #(
        .DB_CYCLES    (4),
        .STUCK_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_a       (raw_a),
        .raw_b       (raw_b),
        .clear_fault (clear_fault),
        .a           (a),
        .b           (b),
        .fault_a     (fault_a),
        .fault_b     (fault_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e, input logic ea, input logic eb,
                           input logic efa, input logic efb);
        check($sformatf("%s a e%0d", tag, e), a, ea);
        check($sformatf("%s b e%0d", tag, e), b, eb);
        check($sformatf("%s fault_a e%0d", tag, e), fault_a, efa);
        check($sformatf("%s fault_b e%0d", tag, e), fault_b, efb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};

        rst         = 1'b1;
        raw_a       = 1'b0;
        raw_b       = 1'b0;
        clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset_hold", 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_all("after_reset", 0, 0, 0, 0, 0);
        $display("[TB] reset state checked");

        // Clean step: rise on edge 6 after the first sampling edge, fall likewise.
        raw_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            chk_all("step_rise", e, e >= 6, 0, 0, 0);
        end
        raw_a = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            chk_all("step_fall", e, e < 6, 0, 0, 0);
        end
        $display("[TB] clean step done");

        // Bounce: 3-cycle excursions never reach DB_CYCLES, then a solid hold.
        for (int e = 1; e <= 10; e++) begin
            raw_a = pat[e-1][0];
            @(negedge clk);
            chk_all("bounce", e, 0, 0, 0, 0);
        end
        raw_a = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            chk_all("bounce_hold", e, e >= 6, 0, 0, 0);
        end
        raw_a = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            chk_all("bounce_release", e, e < 6, 0, 0, 0);
        end
        $display("[TB] bounce filter done");

        // Overlapping car entry: outputs trail the raw edges by the same latency.
        for (int e = 1; e <= 20; e++) begin
            raw_a = (e >= 1 && e <= 8);
            raw_b = (e >= 4 && e <= 11);
            @(negedge clk);
            chk_all("parallel", e, (e - 5 >= 1) && (e - 5 <= 8), (e - 5 >= 4) && (e - 5 <= 11), 0, 0);
        end
        raw_a = 1'b0;
        raw_b = 1'b0;
        $display("[TB] parallel entry done");

        // Stuck b: fault after 15 visible cycles, clear, then fault again.
        raw_b = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            clear_fault = (e == 41);
            @(negedge clk);
            if (e <= 40)
                chk_all("stuck_b", e, 0, (e >= 6) && (e < 21), 0, e >= 21);
            else
                chk_all("stuck_b_clr", e, 0, e < 56, 0, e >= 56);
        end
        clear_fault = 1'b0;
        $display("[TB] stuck sensor done");

        // clear_fault lands on the edge scnt_a would hit the threshold; it also re-arms b.
        raw_a = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            clear_fault = (e == 21);
            @(negedge clk);
            chk_all("priority", e, (e >= 6) && (e < 36), (e >= 21) && (e < 36), e >= 36,
                    (e < 21) || (e >= 36));
        end
        clear_fault = 1'b0;
        raw_a = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            chk_all("a_release", e, 0, 0, 1, 1);
        end
        $display("[TB] clear priority done");

        // Asynchronous reset in the middle of a debounce while both faults are set.
        raw_a = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0);
        raw_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            chk_all("post_rst", e, e >= 6, 0, 0, 0);
        end
        $display("[TB] async reset done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
